// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin scheduler (arb_rr_sched).
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width; a single-bit index is kept even for degenerate N.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wait counter must hold WAIT_MAX itself so it can saturate there.
  function automatic int wcnt_w(input int wait_max);
    return $clog2(wait_max + 1);
  endfunction

endpackage

// File: rtl/arb_rr_sched_rr_pick.sv
// Rotating priority encoder: first set bit of vec at or above ptr, wrapping N-1 -> 0.
module rr_pick #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int j;

  // Scan offsets from far to near so the nearest set bit is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (vec[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/arb_rr_sched.sv
// Registered round-robin scheduler with acknowledge watchdog.
// Optional urgent-request mask enabled by defining ARB_PRIO_EN.
module arb_rr_sched
  import arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req_i,
`ifdef ARB_PRIO_EN
  input  logic [N-1:0]        prio,
`endif
  output logic [N-1:0]        ack_i,
  output logic [idx_w(N)-1:0] gnt_id,
  output logic                req_o,
  input  logic                ack_o,
  output logic                busy,
  output logic                timeout_o
);

  localparam int IDX_W  = idx_w(N);
  localparam int WCNT_W = wcnt_w(WAIT_MAX);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);
  localparam logic [WCNT_W-1:0] WAIT_SAT  = WCNT_W'(WAIT_MAX);
  localparam logic [N-1:0]      ONE_HOT0  = N'(1);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [WCNT_W-1:0]  wcnt;
  logic [N-1:0]       pick_vec;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  function automatic logic [WCNT_W-1:0] wcnt_inc(input logic [WCNT_W-1:0] cnt);
    return (cnt == WAIT_SAT) ? cnt : cnt + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] id);
    return (id == IDX_W'(N - 1)) ? '0 : id + 1'b1;
  endfunction

`ifdef ARB_PRIO_EN
  // Urgent requesters pre-empt the rotation only when any of them is pending.
  assign pick_vec = (|(req_i & prio)) ? (req_i & prio) : req_i;
`else
  assign pick_vec = req_i;
`endif

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .vec   (pick_vec),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = WAIT;
      WAIT: begin
        if (ack_o)                  state_nxt = DONE;
        else if (wcnt == WAIT_LAST) state_nxt = IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so nothing is combinational.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_id    <= '0;
      ack_i     <= '0;
      req_o     <= 1'b0;
      busy      <= 1'b0;
      timeout_o <= 1'b0;
      wcnt      <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      req_o     <= (state_nxt == WAIT);
      ack_i     <= '0;
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt_id <= pick_idx;
            wcnt   <= '0;
          end
        end
        WAIT: begin
          wcnt <= wcnt_inc(wcnt);
          if (ack_o)                  ack_i     <= ONE_HOT0 << gnt_id;
          else if (wcnt == WAIT_LAST) timeout_o <= 1'b1;
          // Advancing past the winner on abort too keeps a dead requester from starving others.
          if (state_nxt != WAIT)      ptr       <= ptr_after(gnt_id);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_rr_sched.sv
// Scoreboard bench for arb_rr_sched (N=8, WAIT_MAX=4); urgent-mask vectors run when ARB_PRIO_EN is defined.
module tb_arb_rr_sched;

  localparam int N        = 8;
  localparam int WAIT_MAX = 4;

  typedef struct packed {
    logic         to;
    logic [N-1:0] ack;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_i;
`ifdef ARB_PRIO_EN
  logic [N-1:0] prio;
`endif
  logic [N-1:0] ack_i;
  logic [2:0]   gnt_id;
  logic         req_o;
  logic         ack_o;
  logic         busy;
  logic         timeout_o;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  arb_rr_sched #(
    .N        (N),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
`ifdef ARB_PRIO_EN
    .prio      (prio),
`endif
    .ack_i     (ack_i),
    .gnt_id    (gnt_id),
    .req_o     (req_o),
    .ack_o     (ack_o),
    .busy      (busy),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every ack_i or timeout_o pulse must match the next queued expectation.
  always @(negedge clk) begin
    if ((ack_i != '0) || (timeout_o == 1'b1)) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got ack_i=%h timeout_o=%b, expected no pulse", ack_i, timeout_o);
      end else begin
        mon_e = sbq.pop_front();
        if ((ack_i !== mon_e.ack) || (timeout_o !== mon_e.to)) begin
          errors++;
          $display("FAIL pulse: got ack_i=%h timeout_o=%b, expected ack_i=%h timeout_o=%b",
                   ack_i, timeout_o, mon_e.ack, mon_e.to);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_req(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (req_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: req_o got 0 for 12 cycles, expected 1", name);
    end
  endtask

  // Waits for a grant, checks the winner, holds ack_o low for 'delay' WAIT cycles, then acks.
  task automatic grant(input string name, input int exp_id, input int delay, input bit drop,
                       output int rise);
    bit ok;
    wait_req(name, ok);
    rise = cyc;
    if (!ok) return;
    chk({name, "_gnt"}, 32'(gnt_id), exp_id);
    sbq.push_back(exp_t'{to: 1'b0, ack: N'(1) << exp_id});
    if (drop) req_i = '0;
    for (int i = 0; i < delay; i++) tick();
    chk({name, "_req_before_ack"}, 32'(req_o), 1);
    ack_o = 1'b1;
    tick();
    ack_o = 1'b0;
    chk({name, "_req_in_done"}, 32'(req_o), 0);
    chk({name, "_busy_in_done"}, 32'(busy), 1);
  endtask

  initial begin
    bit ok;
    int rise;
    int last;
    int hi;
    rst   = 1'b1;
    req_i = '0;
    ack_o = 1'b0;
`ifdef ARB_PRIO_EN
    prio  = '0;
`endif
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req_o", 32'(req_o), 0);
    chk("rst_ack_i", 32'(ack_i), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    chk("rst_gnt_id", 32'(gnt_id), 0);
    rst = 1'b0;

    // Idle: nothing requested; ack_o in the second half must be ignored.
    for (int i = 0; i < 10; i++) begin
      if (i >= 5) ack_o = 1'b1;
      tick();
      chk("idle_busy", 32'(busy), 0);
      chk("idle_req_o", 32'(req_o), 0);
      chk("idle_ack_i", 32'(ack_i), 0);
    end
    ack_o = 1'b0;

    // Two requesters alternate; immediate ack gives minimum grant spacing of 3.
    req_i = 8'h81;
    last  = 0;
    for (int k = 0; k < 4; k++) begin
      grant("alt", (k % 2 == 1) ? 7 : 0, 0, 1'b0, rise);
      if (k > 0) chk("alt_spacing", 32'(rise - last), 3);
      last = rise;
    end
    req_i = '0;
    tick();

    // Timeout: requester 2 never acked; req_o high WAIT_MAX cycles then abort.
    req_i = 8'h04;
    wait_req("to", ok);
    chk("to_gnt", 32'(gnt_id), 2);
    sbq.push_back(exp_t'{to: 1'b1, ack: '0});
    req_i = '0;
    hi = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (req_o === 1'b1) hi++;
      else break;
    end
    chk("to_req_cycles", 32'(hi), WAIT_MAX);
    chk("to_busy_after", 32'(busy), 0);
    tick();

    // Pointer now 3: 0x0D picks 3; ack on the last WAIT cycle beats the timeout.
    req_i = 8'h0D;
    grant("ackwin", 3, WAIT_MAX - 1, 1'b1, rise);
    chk("ackwin_no_timeout", 32'(timeout_o), 0);
    tick();

    // Winner latched even after its request drops; ack two cycles later.
    req_i = 8'h02;
    grant("drop", 1, 2, 1'b1, rise);
    tick();

    // Reset during WAIT: immediate return to reset values, no pulses.
    req_i = 8'h10;
    wait_req("midrst", ok);
    chk("midrst_gnt", 32'(gnt_id), 4);
    req_i = '0;
    ack_o = 1'b1;
    rst   = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_req_o", 32'(req_o), 0);
    chk("midrst_ack_i", 32'(ack_i), 0);
    chk("midrst_timeout", 32'(timeout_o), 0);
    chk("midrst_gnt_id", 32'(gnt_id), 0);
    rst   = 1'b0;
    ack_o = 1'b0;
    tick();
    chk("midrst_ack_i_after", 32'(ack_i), 0);

    // Pointer reset to 0: 0x06 picks 1, not 2.
    req_i = 8'h06;
    grant("ptr0", 1, 0, 1'b1, rise);
    tick();

`ifdef ARB_PRIO_EN
    // Urgent mask 0x30 confines rotation to 4,5; clearing it resumes from ptr 6.
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    req_i = 8'hFF;
    prio  = 8'h30;
    for (int k = 0; k < 4; k++) grant("prio", (k % 2 == 1) ? 5 : 4, 0, 1'b0, rise);
    prio = '0;
    grant("prio_off_a", 6, 0, 1'b0, rise);
    grant("prio_off_b", 7, 0, 1'b1, rise);
    tick();
`endif

    repeat (5) tick();
    chk("sb_empty", 32'(sbq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
